output_collector: RTL and testbench



---
 rtl/output_pkg.sv | 23 ++
 rtl/output_collector_word_bank.sv | 33 +++
 rtl/output_collector.sv | 160 ++++++++++++++++
 tb/tb_output_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// Shared types and helpers for the output collector: FSM states, default sizes, popcount.
package output_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } coll_state_e;

    localparam int DATA_W_DEF    = 32;
    localparam int NUM_WORDS_DEF = 4;
    localparam int POP_MAX_W     = 64;

    // Counts set bits of a bitmap zero-extended to POP_MAX_W bits
    function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/output_collector_word_bank.sv
// NUM_WORDS x DATA_W register bank with a single indexed write port and a packed read bus.
module word_bank
    import output_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             idx_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic [DATA_W*NUM_WORDS-1:0]   bank_o
);

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        logic [DATA_W-1:0] word_q;

        // Word storage: cleared only by reset, otherwise loaded when selected
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                word_q <= '0;
            end else if (we_i && (idx_i == ADDR_W'(i))) begin
                word_q <= data_i;
            end
        end

        // Word 0 occupies the most significant slot of the packed bus
        assign bank_o[(NUM_WORDS-1-i)*DATA_W +: DATA_W] = word_q;
    end

endmodule

// File: rtl/output_collector.sv
// Collects NUM_WORDS result words and hands the packed frame out under valid/ready.
// Optional sticky write-error flag enabled by defining OUTPUT_COLLECTOR_ERR_EN.
module output_collector
    import output_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                              Clock,
    input  logic                              Res,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic                              wr_seq,
    input  logic [$clog2(NUM_WORDS)-1:0]      wr_addr,
    input  logic [DATA_W-1:0]                 in_data,
    output logic                              wr_ready,
    output logic [$clog2(NUM_WORDS):0]        fill_cnt,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef OUTPUT_COLLECTOR_ERR_EN
    output logic                              wr_err,
`endif
    output logic [DATA_W*NUM_WORDS-1:0]       out_data
);

    localparam int ADDR_W = $clog2(NUM_WORDS);

    coll_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_WORDS-1:0]    filled_q, filled_d;
    logic [ADDR_W-1:0]       idx_s;
    logic                    idx_ok_s;
    logic                    wr_acc_s;
    logic [NUM_WORDS-1:0]    onehot_s;
    logic [POP_MAX_W-1:0]    filled_ext_s;
    logic [6:0]              pop_s;

    // Write index selection, range check and acceptance qualification
    always_comb begin
        idx_s    = wr_seq ? ptr_q : wr_addr;
        idx_ok_s = ({1'b0, idx_s} < (ADDR_W+1)'(NUM_WORDS));
        wr_acc_s = (state_q == ST_FILL) && wr_en && idx_ok_s && !clear;
        onehot_s = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            onehot_s[i] = (idx_s == ADDR_W'(i));
        end
    end

    // Next-state logic; clear overrides both handshake and writes
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        filled_d = filled_q;
        if (clear) begin
            state_d  = ST_FILL;
            ptr_d    = '0;
            filled_d = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_acc_s) begin
                        filled_d = filled_q | onehot_s;
                        if (wr_seq) begin
                            ptr_d = (ptr_q == ADDR_W'(NUM_WORDS-1)) ? '0 : ptr_q + 1'b1;
                        end else begin
                            ptr_d = ptr_q;
                        end
                        if (&filled_d) begin
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d  = ST_FILL;
                        ptr_d    = '0;
                        filled_d = '0;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d  = ST_FILL;
                    ptr_d    = '0;
                    filled_d = '0;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge Clock) begin
        if (!Res) begin
            state_q  <= ST_FILL;
            ptr_q    <= '0;
            filled_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            filled_q <= filled_d;
        end
    end

`ifdef OUTPUT_COLLECTOR_ERR_EN
    logic err_q, err_d;

    // Sticky error: dropped writes or overwrites of an already-filled word
    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if (wr_en && ((state_q == ST_FULL) || !idx_ok_s)) begin
            err_d = 1'b1;
        end else if (wr_acc_s && ((filled_q & onehot_s) != '0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register
    always_ff @(posedge Clock) begin
        if (!Res) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wr_err = err_q;
`endif

    word_bank #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk_i   (Clock),
        .rst_n_i (Res),
        .we_i    (wr_acc_s),
        .idx_i   (idx_s),
        .data_i  (in_data),
        .bank_o  (out_data)
    );

    // Status decode from registered state and fill bitmap
    always_comb begin
        filled_ext_s                = '0;
        filled_ext_s[NUM_WORDS-1:0] = filled_q;
        pop_s                       = popcount(filled_ext_s);
        fill_cnt                    = pop_s[ADDR_W:0];
        out_valid                   = (state_q == ST_FULL);
        wr_ready                    = (state_q == ST_FILL);
    end

endmodule

// File: tb/tb_output_collector.sv
// Directed self-checking bench: default 4x32 collector plus a 5x16 instance.
module tb_output_collector;

    logic clk;
    logic rst_n;

    logic         a_clear, a_wr_en, a_wr_seq, a_out_ready;
    logic [1:0]   a_wr_addr;
    logic [31:0]  a_in_data;
    logic         a_wr_ready, a_out_valid;
    logic [2:0]   a_fill_cnt;
    logic [127:0] a_out_data;

    logic         b_clear, b_wr_en, b_wr_seq, b_out_ready;
    logic [2:0]   b_wr_addr;
    logic [15:0]  b_in_data;
    logic         b_wr_ready, b_out_valid;
    logic [3:0]   b_fill_cnt;
    logic [79:0]  b_out_data;

`ifdef OUTPUT_COLLECTOR_ERR_EN
    logic a_wr_err, b_wr_err;
`endif

    int nvec = 0;
    int nmis = 0;

    output_collector u_dut_a (
        .Clock     (clk),
        .Res       (rst_n),
        .clear     (a_clear),
        .wr_en     (a_wr_en),
        .wr_seq    (a_wr_seq),
        .wr_addr   (a_wr_addr),
        .in_data   (a_in_data),
        .wr_ready  (a_wr_ready),
        .fill_cnt  (a_fill_cnt),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
`ifdef OUTPUT_COLLECTOR_ERR_EN
        .wr_err    (a_wr_err),
`endif
        .out_data  (a_out_data)
    );

    output_collector #(.DATA_W(16), .NUM_WORDS(5)) u_dut_b (
        .Clock     (clk),
        .Res       (rst_n),
        .clear     (b_clear),
        .wr_en     (b_wr_en),
        .wr_seq    (b_wr_seq),
        .wr_addr   (b_wr_addr),
        .in_data   (b_in_data),
        .wr_ready  (b_wr_ready),
        .fill_cnt  (b_fill_cnt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
`ifdef OUTPUT_COLLECTOR_ERR_EN
        .wr_err    (b_wr_err),
`endif
        .out_data  (b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq_data [4];
    logic [31:0] adr_data [5];
    logic [1:0]  adr_addr [5];
    logic [2:0]  adr_cnt  [5];
    logic [127:0] frame;

    initial begin
        seq_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        adr_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hEEEE_0005};
        adr_addr = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd2};
        adr_cnt  = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};

        rst_n = 1'b0;
        a_clear = 1'b0; a_wr_en = 1'b0; a_wr_seq = 1'b0; a_out_ready = 1'b0;
        a_wr_addr = 2'd0; a_in_data = 32'd0;
        b_clear = 1'b0; b_wr_en = 1'b0; b_wr_seq = 1'b0; b_out_ready = 1'b0;
        b_wr_addr = 3'd0; b_in_data = 16'd0;
        tick();
        tick();
        check_val("rst_out_data", 160'(a_out_data), 160'd0);
        check_val("rst_wr_ready", 160'(a_wr_ready), 160'd1);
        check_val("rst_out_valid", 160'(a_out_valid), 160'd0);
        check_val("rst_fill_cnt", 160'(a_fill_cnt), 160'd0);
`ifdef OUTPUT_COLLECTOR_ERR_EN
        check_val("rst_wr_err", 160'(a_wr_err), 160'd0);
`endif
        rst_n = 1'b1;

        // Sequential fill
        a_wr_en = 1'b1; a_wr_seq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = seq_data[i];
            tick();
            check_val("seq_fill_cnt", 160'(a_fill_cnt), 160'(i + 1));
            check_val("seq_out_valid", 160'(a_out_valid), (i == 3) ? 160'd1 : 160'd0);
        end
        frame = 128'h11111111_22222222_33333333_44444444;
        check_val("seq_out_data", 160'(a_out_data), 160'(frame));
        check_val("seq_wr_ready", 160'(a_wr_ready), 160'd0);

        // Backpressure with writes attempted while full
        a_in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_out_data", 160'(a_out_data), 160'(frame));
            check_val("bp_wr_ready", 160'(a_wr_ready), 160'd0);
            check_val("bp_out_valid", 160'(a_out_valid), 160'd1);
`ifdef OUTPUT_COLLECTOR_ERR_EN
            check_val("bp_wr_err", 160'(a_wr_err), 160'd1);
`endif
        end
        a_wr_en = 1'b0; a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check_val("hs_out_valid", 160'(a_out_valid), 160'd0);
        check_val("hs_fill_cnt", 160'(a_fill_cnt), 160'd0);
        check_val("hs_wr_ready", 160'(a_wr_ready), 160'd1);
        check_val("hs_words_kept", 160'(a_out_data), 160'(frame));
`ifdef OUTPUT_COLLECTOR_ERR_EN
        check_val("hs_wr_err_sticky", 160'(a_wr_err), 160'd1);
`endif
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
`ifdef OUTPUT_COLLECTOR_ERR_EN
        check_val("clr_wr_err", 160'(a_wr_err), 160'd0);
`endif

        // Addressed out-of-order writes with one rewrite
        a_wr_en = 1'b1; a_wr_seq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_wr_addr = adr_addr[i];
            a_in_data = adr_data[i];
            tick();
            check_val("adr_fill_cnt", 160'(a_fill_cnt), 160'(adr_cnt[i]));
            check_val("adr_out_valid", 160'(a_out_valid), (i == 4) ? 160'd1 : 160'd0);
`ifdef OUTPUT_COLLECTOR_ERR_EN
            check_val("adr_wr_err", 160'(a_wr_err), (i >= 2) ? 160'd1 : 160'd0);
`endif
        end
        a_wr_en = 1'b0;
        check_val("adr_out_data", 160'(a_out_data),
                  160'({32'hDDDD_0004, 32'hCCCC_0003, 32'hEEEE_0005, 32'hAAAA_0001}));
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check_val("adr_hs_valid", 160'(a_out_valid), 160'd0);

        // Clear mid-frame, then the next sequential write lands in word 0
        a_wr_en = 1'b1; a_wr_seq = 1'b1;
        a_in_data = 32'h5555_0001;
        tick();
        a_in_data = 32'h5555_0002;
        tick();
        check_val("mid_fill_cnt", 160'(a_fill_cnt), 160'd2);
        a_wr_en = 1'b0; a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check_val("clr_fill_cnt", 160'(a_fill_cnt), 160'd0);
        check_val("clr_out_valid", 160'(a_out_valid), 160'd0);
        a_wr_en = 1'b1; a_in_data = 32'h6666_0006;
        tick();
        a_wr_en = 1'b0;
        check_val("clr_word0", 160'(a_out_data[127:96]), 160'(32'h6666_0006));
        check_val("clr_word1_kept", 160'(a_out_data[95:64]), 160'(32'h5555_0002));
        check_val("clr_next_cnt", 160'(a_fill_cnt), 160'd1);

        // Non-default instance: out-of-range address then five sequential writes
        b_wr_en = 1'b1; b_wr_seq = 1'b0; b_wr_addr = 3'd7; b_in_data = 16'hFFFF;
        tick();
        check_val("b_oob_fill_cnt", 160'(b_fill_cnt), 160'd0);
        check_val("b_oob_out_data", 160'(b_out_data), 160'd0);
`ifdef OUTPUT_COLLECTOR_ERR_EN
        check_val("b_oob_wr_err", 160'(b_wr_err), 160'd1);
`endif
        b_wr_seq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            b_in_data = 16'(i);
            tick();
            check_val("b_fill_cnt", 160'(b_fill_cnt), 160'(i));
            check_val("b_out_valid", 160'(b_out_valid), (i == 5) ? 160'd1 : 160'd0);
        end
        b_wr_en = 1'b0;
        check_val("b_out_data", 160'(b_out_data), 160'(80'h0001_0002_0003_0004_0005));
        check_val("b_wr_ready", 160'(b_wr_ready), 160'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
